// File: rtl/node_pkg.sv
// rtl/node_pkg.sv - shared FSM state, accumulator sizing and result helpers for neuron_mac_node
package node_pkg;

   // Working width of the result helpers; any legal accumulator fits inside it.
   localparam int MAXW = 128;

   typedef logic signed [MAXW-1:0] wide_t;

   typedef enum logic [1:0] {
      IDLE,
      MAC,
      ROUND,
      OUT
   } node_state_t;

   // Product width plus growth for N_IN terms plus the bias term.
   function automatic int acc_width(input int n_in, input int dw);
      return 2 * dw + $clog2(n_in) + 1;
   endfunction

   // Round-half-up then drop the fractional bits (arithmetic shift).
   function automatic wide_t round_shift(input wide_t acc, input int frac);
      wide_t half;
      wide_t res;
      if (frac > 0) begin
         half = wide_t'(1) <<< (frac - 1);
         res  = (acc + half) >>> frac;
      end else begin
         half = '0;
         res  = acc + half;
      end
      return res;
   endfunction

   // Clamp to the signed range of a dw-bit word.
   function automatic wide_t sat_dw(input wide_t r, input int dw);
      wide_t hi;
      wide_t lo;
      wide_t res;
      hi = (wide_t'(1) <<< (dw - 1)) - wide_t'(1);
      lo = -hi - wide_t'(1);
      if (r > hi)      res = hi;
      else if (r < lo) res = lo;
      else             res = r;
      return res;
   endfunction

   // Negative values become zero.
   function automatic wide_t relu(input wide_t v);
      wide_t res;
      if (v[MAXW-1]) res = '0;
      else           res = v;
      return res;
   endfunction

endpackage

// File: rtl/node_weight_rf.sv
// rtl/node_weight_rf.sv - N_IN weights plus one bias word, sync write, sync clear, combinational read
module node_weight_rf
   import node_pkg::*;
#(
   parameter int N_IN = 15,
   parameter int DW   = 16,
   parameter int AW   = $clog2(N_IN + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data,
   output logic [DW-1:0] bias
);

   // Entry N_IN holds the bias; 0..N_IN-1 are the weights.
   logic [DW-1:0] mem [N_IN+1];
   logic          wr_ok;
   logic          rd_ok;

   // Address range checks only exist when the address field can exceed the table.
   if ((2 ** AW) > (N_IN + 1)) begin : g_range_chk
      assign wr_ok = (wr_addr <= AW'(N_IN));
      assign rd_ok = (rd_addr <= AW'(N_IN));
   end else begin : g_range_full
      assign wr_ok = 1'b1;
      assign rd_ok = 1'b1;
   end

   // Clear everything on reset, otherwise take in-range writes.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i <= N_IN; i++) mem[i] <= '0;
      end else if (we && wr_ok) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Out-of-range read indices return zero.
   always_comb begin
      rd_data = '0;
      if (rd_ok) rd_data = mem[rd_addr];
   end

   assign bias = mem[N_IN];

endmodule

// File: rtl/neuron_mac_node.sv
// rtl/neuron_mac_node.sv - one ReLU neuron, single time-shared multiplier; NEURON_MAC_NODE_SAT_EN selects saturation over wrap
module neuron_mac_node
   import node_pkg::*;
#(
   parameter int N_IN      = 15,
   parameter int DW        = 16,
   parameter int FRAC_BITS = 0,
   parameter int ACC_W     = acc_width(N_IN, DW)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       w_we,
   input  logic [$clog2(N_IN+1)-1:0]  w_addr,
   input  logic [DW-1:0]              w_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [N_IN*DW-1:0]         in_vec,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DW-1:0]              out_data,
   output logic                       busy
);

   localparam int AW = $clog2(N_IN + 1);

   node_state_t              state;
   logic signed [ACC_W-1:0]  acc;
   logic [AW-1:0]            idx;
   logic [N_IN*DW-1:0]       x_reg;
   logic                     rf_we;
   logic [DW-1:0]            w_cur;
   logic [DW-1:0]            bias_rf;
   logic signed [DW-1:0]     bias_eff;
   logic signed [DW-1:0]     x_cur;
   logic signed [2*DW-1:0]   prod;
   logic [DW-1:0]            res_next;

   // Coefficients are only writable while no vector is in flight.
   assign rf_we = w_we && (state == IDLE);

   node_weight_rf #(
      .N_IN (N_IN),
      .DW   (DW),
      .AW   (AW)
   ) u_rf (
      .clk     (clk),
      .reset   (reset),
      .we      (rf_we),
      .wr_addr (w_addr),
      .wr_data (w_data),
      .rd_addr (idx),
      .rd_data (w_cur),
      .bias    (bias_rf)
   );

   // A bias write coinciding with an accept must seed this computation.
   assign bias_eff = (w_we && (w_addr == AW'(N_IN))) ? w_data : bias_rf;

   // Pick the captured input that pairs with the current weight.
   always_comb begin
      x_cur = '0;
      for (int i = 0; i < N_IN; i++) begin
         if (idx == AW'(i)) x_cur = x_reg[i*DW +: DW];
      end
   end

   assign prod = (2*DW)'(x_cur) * (2*DW)'($signed(w_cur));

`ifdef NEURON_MAC_NODE_SAT_EN
   assign res_next = DW'(relu(sat_dw(round_shift(wide_t'(acc), FRAC_BITS), DW)));
`else
   logic signed [DW-1:0] r_wrap;
   assign r_wrap   = DW'(round_shift(wide_t'(acc), FRAC_BITS));
   assign res_next = DW'(relu(wide_t'(r_wrap)));
`endif

   // Control FSM: capture, N_IN multiply-accumulates, round, hold until taken.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         acc       <= '0;
         idx       <= '0;
         x_reg     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  x_reg    <= in_vec;
                  acc      <= ACC_W'(bias_eff) <<< FRAC_BITS;
                  idx      <= '0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= MAC;
               end
            end
            MAC: begin
               acc <= acc + ACC_W'(prod);
               idx <= idx + AW'(1);
               if (idx == AW'(N_IN - 1)) state <= ROUND;
            end
            ROUND: begin
               out_data  <= res_next;
               out_valid <= 1'b1;
               state     <= OUT;
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_neuron_mac_node.sv
// tb/tb_neuron_mac_node.sv - bench for neuron_mac_node (integer and Q8 instances)
module tb_neuron_mac_node;

   localparam int N_IN = 3;
   localparam int DW   = 16;
   localparam int AW   = 2;
   localparam int TO   = 50;
`ifdef NEURON_MAC_NODE_SAT_EN
   localparam int OVF_EXP = 32767;
`else
   localparam int OVF_EXP = 0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 reset     [2];
   logic                 w_we      [2];
   logic [AW-1:0]        w_addr    [2];
   logic [DW-1:0]        w_data    [2];
   logic                 in_valid  [2];
   logic                 in_ready  [2];
   logic [N_IN*DW-1:0]   in_vec    [2];
   logic                 out_valid [2];
   logic                 out_ready [2];
   logic [DW-1:0]        out_data  [2];
   logic                 busy      [2];

   int checks = 0;
   int errors = 0;
   bit live   = 1'b0;

   neuron_mac_node #(.N_IN(N_IN), .DW(DW), .FRAC_BITS(0)) u_dut0 (
      .clk(clk), .reset(reset[0]), .w_we(w_we[0]), .w_addr(w_addr[0]), .w_data(w_data[0]),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_vec(in_vec[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0])
   );

   neuron_mac_node #(.N_IN(N_IN), .DW(DW), .FRAC_BITS(8)) u_dut1 (
      .clk(clk), .reset(reset[1]), .w_we(w_we[1]), .w_addr(w_addr[1]), .w_data(w_data[1]),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_vec(in_vec[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1])
   );

   // Reference model state
   shortint     mw     [2][N_IN];
   shortint     mb     [2];
   bit          pend   [2];
   bit          mvalid [2];
   logic [15:0] mdata  [2];
   logic [15:0] mexp   [2];
   int          age    [2];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int frac_of(input int d);
      return (d == 0) ? 0 : 8;
   endfunction

   // y = ReLU(width_rule(round(sum x*w + b*2^F)))
   function automatic logic [15:0] model_out(input int d, input logic [N_IN*DW-1:0] xv);
      longint  s;
      longint  r;
      shortint t;
      int      f;
      f = frac_of(d);
      s = longint'(mb[d]) * (longint'(1) << f);
      for (int i = 0; i < N_IN; i++) s += longint'(shortint'(xv[i*DW +: DW])) * longint'(mw[d][i]);
      if (f > 0) r = (s + (longint'(1) << (f - 1))) >>> f;
      else       r = s;
`ifdef NEURON_MAC_NODE_SAT_EN
      if (r > 32767)  r = 32767;
      if (r < -32768) r = -32768;
`endif
      t = shortint'(r);
      return (t < 0) ? 16'd0 : 16'(t);
   endfunction

   task automatic model_step();
      for (int d = 0; d < 2; d++) begin
         if (reset[d]) begin
            for (int i = 0; i < N_IN; i++) mw[d][i] = 0;
            mb[d] = 0; pend[d] = 0; mvalid[d] = 0; mdata[d] = '0; age[d] = 0;
         end else if (!pend[d]) begin
            if (w_we[d]) begin
               if (int'(w_addr[d]) == N_IN)    mb[d] = shortint'(w_data[d]);
               else if (int'(w_addr[d]) < N_IN) mw[d][w_addr[d]] = shortint'(w_data[d]);
            end
            if (in_valid[d]) begin
               pend[d] = 1; age[d] = 0; mexp[d] = model_out(d, in_vec[d]);
            end
         end else if (mvalid[d]) begin
            if (out_ready[d]) begin mvalid[d] = 0; pend[d] = 0; end
         end else begin
            age[d]++;
            if (age[d] == N_IN + 1) begin mvalid[d] = 1; mdata[d] = mexp[d]; end
         end
      end
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         mb[d] = 0; pend[d] = 0; mvalid[d] = 0; mdata[d] = '0; mexp[d] = '0; age[d] = 0;
         for (int i = 0; i < N_IN; i++) mw[d][i] = 0;
      end
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (live) begin
            for (int d = 0; d < 2; d++) begin
               check($sformatf("out_valid%0d", d), 64'(out_valid[d]), 64'(mvalid[d]));
               check($sformatf("out_data%0d", d),  64'(out_data[d]),  64'(mdata[d]));
               check($sformatf("in_ready%0d", d),  64'(in_ready[d]),  64'(!pend[d]));
               check($sformatf("busy%0d", d),      64'(busy[d]),      64'(pend[d]));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int d, input int a, input int v);
      w_we[d] = 1'b1; w_addr[d] = AW'(a); w_data[d] = DW'(v);
      tick();
      w_we[d] = 1'b0;
   endtask

   task automatic accept(input int d, input int x0, input int x1, input int x2);
      in_vec[d]   = {DW'(x2), DW'(x1), DW'(x0)};
      in_valid[d] = 1'b1;
      tick();
      in_valid[d] = 1'b0;
   endtask

   task automatic wait_valid(input int d, output int n);
      n = 0;
      while (out_valid[d] !== 1'b1 && n < TO) begin
         tick();
         n++;
      end
      if (n >= TO) begin
         checks++; errors++;
         $display("FAIL timeout%0d: out_valid not seen within %0d cycles", d, TO);
      end
   endtask

   int n;

   initial begin
      for (int d = 0; d < 2; d++) begin
         reset[d] = 1'b1; w_we[d] = 1'b0; w_addr[d] = '0; w_data[d] = '0;
         in_valid[d] = 1'b0; in_vec[d] = '0; out_ready[d] = 1'b1;
      end
      tick(); tick();
      reset[0] = 1'b0; reset[1] = 1'b0;
      live = 1'b1;
      check("reset_out_data", 64'(out_data[0]), 64'd0);
      check("reset_out_valid", 64'(out_valid[0]), 64'd0);
      check("reset_in_ready", 64'(in_ready[0]), 64'd1);

      // Basic: 2*10 - 3*1 + 4*2 + 5 = 30
      wr(0, 0, 2); wr(0, 1, -3); wr(0, 2, 4); wr(0, 3, 5);
      accept(0, 10, 1, 2);
      wait_valid(0, n);
      check("basic_latency", 64'(n), 64'd4);
      check("basic_model", 64'(mexp[0]), 64'd30);
      check("basic_out", 64'(out_data[0]), 64'd30);
      tick();
      check("basic_ready_back", 64'(in_ready[0]), 64'd1);

      // ReLU: -30 + 5 = -25 -> 0
      accept(0, 0, 10, 0);
      wait_valid(0, n);
      check("relu_model", 64'(mexp[0]), 64'd0);
      check("relu_out", 64'(out_data[0]), 64'd0);
      tick();

      // Overflow: 300000
      wr(0, 0, 1000); wr(0, 1, 1000); wr(0, 2, 1000); wr(0, 3, 0);
      accept(0, 100, 100, 100);
      wait_valid(0, n);
      check("ovf_model", 64'(mexp[0]), 64'(OVF_EXP));
      check("ovf_out", 64'(out_data[0]), 64'(OVF_EXP));
      tick();

      // Backpressure: 1000*(1+2+3) = 6000 held while out_ready low
      out_ready[0] = 1'b0;
      accept(0, 1, 2, 3);
      wait_valid(0, n);
      for (int k = 0; k < 5; k++) begin
         check("bp_data", 64'(out_data[0]), 64'd6000);
         check("bp_in_ready", 64'(in_ready[0]), 64'd0);
         if (k == 2) begin
            in_vec[0] = {DW'(9), DW'(9), DW'(9)};
            in_valid[0] = 1'b1;
            tick();
            in_valid[0] = 1'b0;
         end else begin
            tick();
         end
      end
      out_ready[0] = 1'b1;
      tick();
      check("bp_ready_back", 64'(in_ready[0]), 64'd1);
      check("bp_valid_drop", 64'(out_valid[0]), 64'd0);
      repeat (8) tick();

      // Reset during the second MAC cycle
      accept(0, 1, 1, 1);
      tick();
      reset[0] = 1'b1;
      tick();
      reset[0] = 1'b0;
      check("rst_out_valid", 64'(out_valid[0]), 64'd0);
      check("rst_in_ready", 64'(in_ready[0]), 64'd1);
      accept(0, 5, 6, 7);
      wait_valid(0, n);
      check("rst_run_model", 64'(mexp[0]), 64'd0);
      check("rst_run_out", 64'(out_data[0]), 64'd0);
      tick();

      // Q8 rounding: 1.5 * 1.5 = 2.25 -> 0x0240; write during MAC ignored
      wr(1, 0, 'h180);
      accept(1, 'h180, 'h100, 'h100);
      w_we[1] = 1'b1; w_addr[1] = AW'(1); w_data[1] = DW'('h100);
      tick();
      w_we[1] = 1'b0;
      wait_valid(1, n);
      check("q8_model", 64'(mexp[1]), 64'h240);
      check("q8_out", 64'(out_data[1]), 64'h240);
      tick();
      accept(1, 'h180, 'h100, 'h100);
      wait_valid(1, n);
      check("q8_repeat_out", 64'(out_data[1]), 64'h240);
      tick();

      // Half-up: 1 * 0x180 = 1.5 LSB -> 2
      accept(1, 1, 0, 0);
      wait_valid(1, n);
      check("q8_half_model", 64'(mexp[1]), 64'd2);
      check("q8_half_out", 64'(out_data[1]), 64'd2);
      tick();
      repeat (3) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
